// File: rtl/spi_cmd_pkg.sv
// Shared constants, types and helpers for the SPI command slave front end.
package spi_cmd_pkg;
  localparam int BYTE_W        = 8;
  localparam int CNT_W         = 32;
  localparam int TX_RELOAD_DLY = 2;
  localparam logic [CNT_W-1:0] CNT_SAT = 32'hFFFF_FFFF;

  // Index of each SPI pin in the synchronizer array.
  localparam int SCK_I  = 0;
  localparam int MOSI_I = 1;
  localparam int SSEL_I = 2;
  localparam int NUM_IN = 3;

  typedef enum logic {ST_IDLE, ST_FRAME} frame_st_t;

  typedef struct packed {
    logic              done;
    logic              is_cmd;
    logic [BYTE_W-1:0] data;
  } rx_evt_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_SAT) ? v : v + CNT_W'(1);
  endfunction
endpackage

// File: rtl/spi_cmd_slave_if.sv
// SPI pin bundle between the MCU (master) and the command slave.
interface spi_cmd_slave_if;
  logic spi_sck;
  logic spi_mosi;
  logic spi_ssel_n;
  logic spi_miso;
  logic spi_miso_oe;

  modport master (output spi_sck, spi_mosi, spi_ssel_n, input spi_miso, spi_miso_oe);
  modport slave  (input spi_sck, spi_mosi, spi_ssel_n, output spi_miso, spi_miso_oe);
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin with edge strobes taken
// between the last two stages; level is the last stage.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  =  sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];
  assign fall  = ~sync_q[SYNC_STAGES-2] &  sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/spi_cmd_slave.sv
// SPI mode-0 slave framing command/parameter bytes for mcu_cmd and shifting
// its reply out on MISO. Optional idle abort: define SPI_CMD_TIMEOUT_EN.
module spi_cmd_slave
  import spi_cmd_pkg::*;
#(
  parameter int SYNC_STAGES    = 3,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spi_cmd_slave_if.slave       spi,
  input  logic [BYTE_W-1:0]    input_data,
  output logic                 cmd_ready,
  output logic                 param_ready,
  output logic [BYTE_W-1:0]    cmd_data,
  output logic [BYTE_W-1:0]    param_data,
  output logic [CNT_W-1:0]     byte_cnt,
  output logic [2:0]           bit_cnt,
  output logic                 spi_timeout
);
  logic [NUM_IN-1:0] pin, lvl, rise, fall;

  assign pin = {spi.spi_ssel_n, spi.spi_mosi, spi.spi_sck};

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync [NUM_IN-1:0] (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (pin),
    .level (lvl),
    .rise  (rise),
    .fall  (fall)
  );

  logic unused_edges;
  assign unused_edges = ^{lvl[SCK_I], rise[MOSI_I], fall[MOSI_I]};

  // A frame opens only on a seen SSEL fall, so a select already low when
  // reset releases is ignored until it cycles high.
  frame_st_t state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (fall[SSEL_I]) state_d = ST_FRAME;
      ST_FRAME: if (rise[SSEL_I] || lvl[SSEL_I]) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  logic frame_act, sck_rise_act, tmo_hit;
  assign frame_act    = (state_q == ST_FRAME) && !rise[SSEL_I];
  assign sck_rise_act = frame_act && rise[SCK_I];

  logic [BYTE_W-1:0] rx_q, rx_nxt, tx_q;
  logic [2:0]        bit_cnt_q;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_nxt;
  rx_evt_t           evt;

  assign rx_nxt       = {rx_q[BYTE_W-2:0], lvl[MOSI_I]};
  assign byte_cnt_nxt = sat_inc(byte_cnt_q);
  assign evt.done     = sck_rise_act && (bit_cnt_q == 3'd7);
  assign evt.is_cmd   = (byte_cnt_nxt == CNT_W'(1));
  assign evt.data     = rx_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_q       <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
    end else if (!frame_act || tmo_hit) begin
      rx_q       <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
    end else if (sck_rise_act) begin
      rx_q      <= rx_nxt;
      bit_cnt_q <= bit_cnt_q + 3'd1;
      if (evt.done) byte_cnt_q <= byte_cnt_nxt;
    end
  end

  logic cmd_ready_q, param_ready_q;
  logic [BYTE_W-1:0] cmd_data_q, param_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready_q   <= 1'b0;
      param_ready_q <= 1'b0;
      cmd_data_q    <= '0;
      param_data_q  <= '0;
    end else begin
      cmd_ready_q   <= evt.done &&  evt.is_cmd;
      param_ready_q <= evt.done && !evt.is_cmd;
      if (evt.done && evt.is_cmd)  cmd_data_q   <= evt.data;
      if (evt.done && !evt.is_cmd) param_data_q <= evt.data;
    end
  end

  // vld_pipe[k] is high k cycles after the completing SCK rise.
  logic [TX_RELOAD_DLY:0] vld_pipe;
  logic [TX_RELOAD_DLY:1] vld_q;
  assign vld_pipe = {vld_q, evt.done};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_q <= '0;
    else        vld_q <= vld_pipe[TX_RELOAD_DLY-1:0];
  end

  // The SCK fall trailing the 8th bit (bit_cnt back at 0) must not shift,
  // or the freshly reloaded MSB would be lost before the next byte starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tx_q <= '0;
    else if (fall[SSEL_I])
      tx_q <= input_data;
    else if (frame_act && vld_pipe[TX_RELOAD_DLY])
      tx_q <= input_data;
    else if (frame_act && fall[SCK_I] && (bit_cnt_q != 3'd0))
      tx_q <= {tx_q[BYTE_W-2:0], 1'b0};
  end

`ifdef SPI_CMD_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [IDLE_W-1:0] idle_q;
  logic              tmo_q;

  assign tmo_hit = frame_act && !rise[SCK_I] && !fall[SCK_I] &&
                   (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      tmo_q <= tmo_hit;
      if (!frame_act || rise[SCK_I] || fall[SCK_I] || tmo_hit) idle_q <= '0;
      else                                                     idle_q <= idle_q + IDLE_W'(1);
    end
  end

  assign spi_timeout = tmo_q;
`else
  logic unused_tmo;
  assign unused_tmo  = (TIMEOUT_CYCLES == 0);
  assign tmo_hit     = 1'b0;
  assign spi_timeout = 1'b0;
`endif

  assign spi.spi_miso    = tx_q[BYTE_W-1];
  assign spi.spi_miso_oe = (state_q == ST_FRAME);
  assign cmd_ready       = cmd_ready_q;
  assign param_ready     = param_ready_q;
  assign cmd_data        = cmd_data_q;
  assign param_data      = param_data_q;
  assign byte_cnt        = byte_cnt_q;
  assign bit_cnt         = bit_cnt_q;
endmodule

// File: tb/tb_spi_cmd_slave.sv
// Directed bench for spi_cmd_slave: scoreboard of expected cmd/param pulses,
// MISO bit checks, abort, reset, saturation and optional idle-abort cases.
module tb_spi_cmd_slave;
  localparam int HP = 8;

  typedef struct packed {
    logic        is_cmd;
    logic [7:0]  data;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  input_data;
  logic        cmd_ready, param_ready, spi_timeout;
  logic [7:0]  cmd_data, param_data;
  logic [31:0] byte_cnt;
  logic [2:0]  bit_cnt;

  int   checks = 0;
  int   errors = 0;
  int   tmo_pulses = 0;
  logic prev_pulse = 1'b0;
  logic [7:0] last_cmd = 8'h00;
  exp_t exp_q[$];

  spi_cmd_slave_if bus();

  spi_cmd_slave #(.SYNC_STAGES(3), .TIMEOUT_CYCLES(100)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spi         (bus),
    .input_data  (input_data),
    .cmd_ready   (cmd_ready),
    .param_ready (param_ready),
    .cmd_data    (cmd_data),
    .param_data  (param_data),
    .byte_cnt    (byte_cnt),
    .bit_cnt     (bit_cnt),
    .spi_timeout (spi_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (spi_timeout) tmo_pulses++;
    if (cmd_ready || param_ready) begin
      chk("pulse_exclusive", {31'd0, cmd_ready & param_ready}, 32'd0);
      chk("pulse_width", {31'd0, prev_pulse}, 32'd0);
      chk("pulse_expected", {31'd0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.is_cmd) last_cmd = e.data;
        chk("pulse_kind", {31'd0, cmd_ready}, {31'd0, e.is_cmd});
        chk("pulse_data", {24'd0, e.is_cmd ? cmd_data : param_data}, {24'd0, e.data});
        chk("pulse_byte_cnt", byte_cnt, e.cnt);
        chk("cmd_data_held", {24'd0, cmd_data}, {24'd0, last_cmd});
      end
    end
    prev_pulse = cmd_ready | param_ready;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ssel_low();
    bus.spi_ssel_n = 1'b0;
    tick(HP);
  endtask

  task automatic ssel_high();
    tick(HP);
    bus.spi_ssel_n = 1'b1;
    tick(HP);
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits,
                           input logic chk_miso, input logic [7:0] exp_miso);
    for (int i = 0; i < nbits; i++) begin
      bus.spi_mosi = b[7-i];
      tick(HP);
      if (chk_miso) chk("miso_bit", {31'd0, bus.spi_miso}, {31'd0, exp_miso[7-i]});
      bus.spi_sck = 1'b1;
      tick(HP);
      bus.spi_sck = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic is_cmd, input logic [31:0] cnt,
                           input logic chk_miso, input logic [7:0] exp_miso);
    exp_t e;
    e.is_cmd = is_cmd;
    e.data   = b;
    e.cnt    = cnt;
    exp_q.push_back(e);
    send_bits(b, 8, chk_miso, exp_miso);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cmd_ready"},   {31'd0, cmd_ready},       32'd0);
    chk({tag, "_param_ready"}, {31'd0, param_ready},     32'd0);
    chk({tag, "_cmd_data"},    {24'd0, cmd_data},        32'd0);
    chk({tag, "_param_data"},  {24'd0, param_data},      32'd0);
    chk({tag, "_byte_cnt"},    byte_cnt,                 32'd0);
    chk({tag, "_bit_cnt"},     {29'd0, bit_cnt},         32'd0);
    chk({tag, "_miso"},        {31'd0, bus.spi_miso},    32'd0);
    chk({tag, "_miso_oe"},     {31'd0, bus.spi_miso_oe}, 32'd0);
    chk({tag, "_timeout"},     {31'd0, spi_timeout},     32'd0);
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.spi_sck    = 1'b0;
    bus.spi_mosi   = 1'b0;
    bus.spi_ssel_n = 1'b1;
    input_data     = 8'h00;
    #1;
    chk_all_zero("reset");
    tick(4);
    rst_n = 1'b1;
    tick(8);

    // Frame 1: command plus three params; reply A5 then 3C on MISO.
    input_data = 8'hA5;
    ssel_low();
    chk("miso_oe_frame", {31'd0, bus.spi_miso_oe}, 32'd1);
    fork
      send_byte(8'h10, 1'b1, 32'd1, 1'b1, 8'hA5);
      begin
        int n;
        n = 0;
        while (!cmd_ready && n < 400) begin
          @(negedge clk);
          n++;
        end
        chk("wait_first_cmd", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        input_data = 8'h3C;
      end
    join
    send_byte(8'h12, 1'b0, 32'd2, 1'b1, 8'h3C);
    send_byte(8'h34, 1'b0, 32'd3, 1'b0, 8'h00);
    send_byte(8'h56, 1'b0, 32'd4, 1'b0, 8'h00);
    tick(4);
    chk("frame1_byte_cnt", byte_cnt, 32'd4);
    ssel_high();
    chk("idle_byte_cnt", byte_cnt, 32'd0);
    chk("idle_bit_cnt", {29'd0, bit_cnt}, 32'd0);
    chk("idle_miso_oe", {31'd0, bus.spi_miso_oe}, 32'd0);
    chk("idle_cmd_data", {24'd0, cmd_data}, 32'h10);
    chk("idle_param_data", {24'd0, param_data}, 32'h56);

    // Frame aborted by SSEL after 5 bits of byte 2.
    ssel_low();
    send_byte(8'h77, 1'b1, 32'd1, 1'b0, 8'h00);
    send_bits(8'h9F, 5, 1'b0, 8'h00);
    tick(4);
    chk("abort_bit_cnt_mid", {29'd0, bit_cnt}, 32'd5);
    chk("abort_byte_cnt_mid", byte_cnt, 32'd1);
    ssel_high();
    chk("abort_bit_cnt", {29'd0, bit_cnt}, 32'd0);
    chk("abort_byte_cnt", byte_cnt, 32'd0);
    chk("abort_param_data", {24'd0, param_data}, 32'h56);
    ssel_low();
    send_byte(8'h42, 1'b1, 32'd1, 1'b0, 8'h00);
    send_byte(8'h43, 1'b0, 32'd2, 1'b0, 8'h00);
    ssel_high();

    // Reset during bit 3 of byte 1 with SSEL held low.
    ssel_low();
    send_bits(8'hC3, 3, 1'b0, 8'h00);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    tick(2);
    rst_n = 1'b1;
    send_bits(8'hC3, 5, 1'b0, 8'h00);
    send_bits(8'h66, 8, 1'b0, 8'h00);
    tick(4);
    chk("stale_ssel_byte_cnt", byte_cnt, 32'd0);
    chk("stale_ssel_bit_cnt", {29'd0, bit_cnt}, 32'd0);
    chk("stale_ssel_miso_oe", {31'd0, bus.spi_miso_oe}, 32'd0);
    ssel_high();
    ssel_low();
    send_byte(8'h5A, 1'b1, 32'd1, 1'b0, 8'h00);
    send_byte(8'h5B, 1'b0, 32'd2, 1'b0, 8'h00);
    ssel_high();

    // Byte counter saturation.
    ssel_low();
    send_byte(8'hE1, 1'b1, 32'd1, 1'b0, 8'h00);
    force dut.byte_cnt_q = 32'hFFFF_FFFE;
    tick(1);
    release dut.byte_cnt_q;
    send_byte(8'h01, 1'b0, 32'hFFFF_FFFF, 1'b0, 8'h00);
    send_byte(8'h02, 1'b0, 32'hFFFF_FFFF, 1'b0, 8'h00);
    send_byte(8'h03, 1'b0, 32'hFFFF_FFFF, 1'b0, 8'h00);
    chk("sat_byte_cnt", byte_cnt, 32'hFFFF_FFFF);
    chk("sat_param_data", {24'd0, param_data}, 32'h03);
    ssel_high();

`ifdef SPI_CMD_TIMEOUT_EN
    // Stalled frame is aborted; the next byte is a fresh command.
    begin
      int base;
      ssel_low();
      send_byte(8'h11, 1'b1, 32'd1, 1'b0, 8'h00);
      send_bits(8'hF0, 4, 1'b0, 8'h00);
      base = tmo_pulses;
      tick(160);
      chk("timeout_pulses", tmo_pulses - base, 32'd1);
      chk("timeout_bit_cnt", {29'd0, bit_cnt}, 32'd0);
      chk("timeout_byte_cnt", byte_cnt, 32'd0);
      send_byte(8'h20, 1'b1, 32'd1, 1'b0, 8'h00);
      tick(4);
      chk("timeout_cmd_data", {24'd0, cmd_data}, 32'h20);
      ssel_high();
    end
`else
    chk("no_timeout_pulses", tmo_pulses, 32'd0);
`endif

    tick(4);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
